// File: rtl/voq_scheduler_pkg.sv
// Shared types and defaults for the egress VOQ scheduler.
package voq_scheduler_pkg;

  localparam int unsigned MEM_ADDR_W        = 12;
  localparam int unsigned VOQ_SCHED_BACKOFF = 8;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF
  } sched_state_e;

endpackage

// File: rtl/voq_scheduler_rr_index_next.sv
// Round-robin successor index; wraps by compare-and-clear so non-power-of-2 counts work.
module rr_index_next #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [W-1:0] i_idx,
  output logic [W-1:0] o_next
);

  always_comb begin
    o_next = '0;
    if (i_idx != W'(N - 1)) begin
      o_next = i_idx + 1'b1;
    end
  end

endmodule

// File: rtl/voq_scheduler.sv
// Polls NUM_VOQ queues round-robin with one outstanding pop and forwards each
// returned pointer, tagged with its source, over a valid/ready output register.
module voq_scheduler
  import voq_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_VOQ     = 4,
  parameter  int unsigned ADDR_W      = MEM_ADDR_W,
  parameter  int unsigned BACKOFF_CYC = VOQ_SCHED_BACKOFF,
  localparam int unsigned SRC_W       = $clog2(NUM_VOQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [NUM_VOQ-1:0]               voq_read_req_o,
  input  logic [NUM_VOQ-1:0][ADDR_W-1:0]   voq_ptr_i,
  input  logic [NUM_VOQ-1:0]               voq_ptr_valid_i,
  output logic [ADDR_W-1:0]                out_ptr_o,
  output logic [SRC_W-1:0]                 out_src_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             idle_o
);

  localparam int unsigned BO_W = $clog2(BACKOFF_CYC) + 1;

  sched_state_e        r_state;
  logic [SRC_W-1:0]    r_rr;
  logic [SRC_W-1:0]    r_sel;
  logic [SRC_W-1:0]    r_miss;
  logic [BO_W-1:0]     r_bo;
  logic [ADDR_W-1:0]   r_out_ptr;
  logic [SRC_W-1:0]    r_out_src;
  logic                r_out_valid;

  logic                w_free;
  logic                w_issue;
  logic                w_hit;
  logic [SRC_W-1:0]    w_next;
  logic [NUM_VOQ-1:0]  w_req;

  rr_index_next #(.N(NUM_VOQ)) u_rr_next (
    .i_idx  (r_sel),
    .o_next (w_next)
  );

  assign w_free  = !r_out_valid || out_ready_i;
  assign w_issue = (r_state == ST_ISSUE) && w_free;
  assign w_hit   = voq_ptr_valid_i[r_sel];

  // The pop must go out in the issue cycle itself so the response lands in
  // ST_WAIT; gating with rst_n keeps the request low while reset is held.
  always_comb begin
    w_req = '0;
    if (w_issue && rst_n) begin
      w_req[r_rr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ISSUE;
      r_rr        <= '0;
      r_sel       <= '0;
      r_miss      <= '0;
      r_bo        <= '0;
      r_out_ptr   <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_ISSUE: begin
          if (w_free) begin
            r_sel   <= r_rr;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_rr <= w_next;
          if (w_hit) begin
            r_out_ptr   <= voq_ptr_i[r_sel];
            r_out_src   <= r_sel;
            r_out_valid <= 1'b1;
            r_miss      <= '0;
            r_state     <= ST_ISSUE;
          end else if (r_miss == SRC_W'(NUM_VOQ - 1)) begin
            r_bo    <= BO_W'(BACKOFF_CYC - 1);
            r_state <= ST_BACKOFF;
          end else begin
            r_miss  <= r_miss + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_BACKOFF: begin
          if (r_bo == '0) begin
            r_miss  <= '0;
            r_state <= ST_ISSUE;
          end else begin
            r_bo <= r_bo - 1'b1;
          end
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

  assign voq_read_req_o = w_req;
  assign out_ptr_o      = r_out_ptr;
  assign out_src_o      = r_out_src;
  assign out_valid_o    = r_out_valid;
  assign idle_o         = (r_state == ST_BACKOFF);

endmodule

// File: doc/voq_scheduler.md
Name: voq_scheduler

Overview:
Egress-side consumer of the virtual output queues. For one output port, it polls NUM_VOQ `voq` instances in round-robin order by pulsing their read request. It captures the popped buffer pointer one cycle later and presents it, with its source index, to the downstream frame reader over a valid/ready handshake. Pops are destructive, so the block must never drop a returned pointer.

Parameters:
NUM_VOQ, 4, number of VOQs polled (one per ingress port), ≥2
ADDR_W, mem_pkg::ADDR_W (12), buffer pointer width
BACKOFF_CYC, 8, idle cycles inserted after a full sweep of misses
SRC_W, $clog2(NUM_VOQ), source index width (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
voq_read_req_o  out  NUM_VOQ  one-hot pop request, at most one bit set, one-cycle pulse
voq_ptr_i  in  NUM_VOQ x ADDR_W  per-VOQ popped pointer
voq_ptr_valid_i  in  NUM_VOQ  per-VOQ pop-valid, registered, one cycle after request
out_ptr_o  out  ADDR_W  pointer to downstream
out_src_o  out  SRC_W  VOQ index the pointer came from
out_valid_o  out  1  output holds a pointer
out_ready_i  in  1  downstream accepts when valid&&ready
idle_o  out  1  high in ST_BACKOFF

Behaviour:
- Reset, asynchronous:
  - all outputs 0
  - state ST_ISSUE
  - rr_q=0, miss_cnt=0, backoff_cnt=0
  - a reset during ST_WAIT discards the in-flight response; the VOQs reset together with this block.
- Output register is free when !out_valid_o, or when out_valid_o && out_ready_i in the current cycle.
- ST_ISSUE:
  - if the output register is free: voq_read_req_o = 1<<rr_q for this cycle, latch sel_q=rr_q, go to ST_WAIT
  - otherwise: no request, stay in ST_ISSUE.
- ST_WAIT: sample voq_ptr_valid_i[sel_q] and voq_ptr_i[sel_q] only; ignore the other VOQs' valids.
  - Hit:
    - out_ptr_o <= voq_ptr_i[sel_q], out_src_o <= sel_q, out_valid_o <= 1
    - miss_cnt <= 0
    - rr_q <= sel_q+1 mod NUM_VOQ
    - go to ST_ISSUE
  - Miss:
    - rr_q <= sel_q+1 mod NUM_VOQ
    - miss_cnt++
    - if miss_cnt reaches NUM_VOQ-1 (this is the NUM_VOQ-th consecutive miss): go to ST_BACKOFF, load backoff_cnt=BACKOFF_CYC-1
    - else go to ST_ISSUE.
- ST_BACKOFF:
  - no requests, idle_o=1
  - decrement backoff_cnt; at 0, clear miss_cnt and go to ST_ISSUE
  - rr_q is unchanged, so the sweep restarts where it stopped.
- Output handshake:
  - out_valid_o clears on valid&&ready unless a hit loads it in the same cycle, in which case the new pointer replaces it.
  - out_ptr_o and out_src_o are stable while valid && !ready.
- Single outstanding request. Peak throughput is one pointer per 2 cycles.
- Round-robin wrap: rr_q goes NUM_VOQ-1 -> 0. Use mod arithmetic for non-power-of-2 NUM_VOQ (compare-and-clear, no truncation).

Decomposition:
- switch_pkg additions:
  - sched_state_e {ST_ISSUE, ST_WAIT, ST_BACKOFF}
  - VOQ_SCHED_BACKOFF default constant
- ADDR_W comes from mem_pkg.
- Sub-module: rr_index_next (combinational next-index with wrap). It is small, so it is optional to inline; no other sub-module is needed.

Test Plan:
Bench instantiates NUM_VOQ=4 real `voq` instances, pushes through their write ports, and connects read ports to the DUT.
1. Reset and release, all VOQs empty -> first cycle after release voq_read_req_o=4'b0001; requests 0001,0010,0100,1000 on alternate cycles; then 8 cycles of 0 with idle_o=1; then 0001 again.
2. VOQ2 loaded {0x010,0x011}, out_ready_i=1 -> out sequence (0x010,src2), (0x011,src2); no other pointers; then backoff.
3. VOQ0 {0x100,0x101}, VOQ1 {0x200}, VOQ3 {0x300} -> order (0x100,0),(0x200,1),(0x300,3),(0x101,0).
4. VOQ1 {0x0A0,0x0A1}, out_ready_i=0 for 10 cycles -> out_ptr_o=0x0A0 stable, no voq_read_req_o during the hold; after ready=1, 0x0A1 follows and nothing is lost.
5. Assert rst_n=0 in ST_WAIT with a response pending -> out_valid_o and voq_read_req_o drop immediately (async); after release, polling restarts at VOQ0.
6. Back-to-back accept with ready held 1, all VOQs loaded with 3 entries -> 12 pointers in strict RR order, consecutive output loads 2 cycles apart.
